mp_add_sequencer: RTL
=====================

Name: mp_add_sequencer

Overview:
Multi-precision add sequencer that shares one DATA_WIDTH-bit ripple-carry word adder across a NUM_WORDS-word operand. It adds one word per cycle, least-significant word first, and chains the carry through a register. It sits between a requester (valid/ready in) and a consumer (valid/ready out), so wide adds need no wide carry chain.

Parameters:
DATA_WIDTH, 8, width of one word and of the shared word adder
NUM_WORDS, 4, words per operand (>=1); operand width W = NUM_WORDS*DATA_WIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request carries valid operands
in_ready  out  1  sequencer can accept a request
a  in  W  operand A
b  in  W  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  W+1  result; sum[W] = final carry
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async assert, any state): state=IDLE, word index=0, carry reg=0, operand regs=0, sum=0, out_valid=0, in_ready=1, busy=0. Aborts any in-flight add; no out_valid for it.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid, capture a, b into operand regs, clear index and carry, clear sum, then go to RUN. a and b are sampled only at acceptance.
  - RUN: each cycle feeds word[idx] of A and B, plus the carry reg, to the word adder. Writes sum word idx and sets carry <= cout. If idx == NUM_WORDS-1, write sum[W] = cout and go to DONE; else idx++.
  - DONE: out_valid=1 and sum held stable. On out_ready, go to IDLE and drop out_valid. Stays in DONE indefinitely under backpressure.
- Timing: acceptance edge is T0; RUN occupies NUM_WORDS cycles; out_valid rises after edge T0+NUM_WORDS. NUM_WORDS=1 yields out_valid after edge T0+1.
- No overlap: in_ready=0 in RUN and DONE. Minimum spacing between accepts is NUM_WORDS+2 cycles.
- Index counter width is max(1,$clog2(NUM_WORDS)) and never exceeds NUM_WORDS-1.
- Arithmetic: result is (A+B) mod 2^(W+1), i.e. a full unsigned sum with no truncation.
- The sum register keeps its last value after the handshake, until the next accept clears it.

Optional Feature:
MP_ADD_SUB_EN
- Defined: adds input port sub (1 bit), captured with the operands at acceptance. With sub=1, B words are inverted and the carry reg initialises to 1, giving A-B.
  - sum[W] = final carry: 1 means no borrow (A>=B), 0 means borrow.
  - With sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Decomposition:
- Package mp_add_pkg:
  - state enum typedef (IDLE, RUN, DONE)
  - localparam function for index width
- Sub-module word_adder: DATA_WIDTH-bit ripple chain of full_adder with explicit cin and cout ports. The existing adder ties carry-in to 0, so it cannot chain words.
- The sequencer instantiates exactly one word_adder.

Test Plan:
- Carry ripple across all words: a=32'hFFFF_FFFF, b=32'h1 (defaults), out_ready=1 → out_valid 4 cycles after accept, sum=33'h1_0000_0000, then in_ready=1 next cycle.
- Plain add: a=32'h1234_5678, b=32'h1111_1111 → sum=33'h0_2345_6789. in_ready=0 throughout RUN/DONE; a/b changes after accept have no effect.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid and sum=33'h0_2345_6789 held stable, in_valid ignored; out_ready=1 → IDLE next cycle.
- Reset mid-RUN: assert rst after 2 words processed → immediately state=IDLE, sum=0, out_valid=0, busy=0; out_valid stays 0 after release; next request completes correctly.
- With MP_ADD_SUB_EN: a=5, b=7, sub=1 → sum=33'h0_FFFF_FFFE (borrow); a=7, b=5, sub=1 → sum=33'h1_0000_0002.
- Random back-to-back requests (1000, random out_ready) → every sum equals a+b (or a-b with sub) checked by scoreboard; no lost or duplicated results.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
// Optional subtract mode is enabled in the sequencer by defining MP_ADD_SUB_EN.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // A one-word operand still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_adder.sv
// DATA_WIDTH-bit ripple-carry adder built from full_adder cells.
// Carry-in and carry-out are exposed so successive words can be chained.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module word_adder #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  cin_i,
    output logic [DATA_WIDTH-1:0] s_o,
    output logic                  cout_o
);
    logic [DATA_WIDTH:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a_i   (a_i[i]),
            .b_i   (b_i[i]),
            .cin_i (c[i]),
            .s_o   (s_o[i]),
            .cout_o(c[i+1])
        );
    end

    assign cout_o = c[DATA_WIDTH];
endmodule

// File: rtl/mp_add_sequencer.sv
// Word-serial multi-precision adder: one shared word adder, LS word first, carry chained in a register.
// Define MP_ADD_SUB_EN to add the 'sub' port (A-B via inverted B and carry-in of 1).
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
`ifdef MP_ADD_SUB_EN
    input  logic                            sub,
`endif
    output logic                            in_ready,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] a,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_WORDS*DATA_WIDTH:0]   sum,
    output logic                            busy
);
    localparam int unsigned IW = idx_width(NUM_WORDS);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    state_e                                 state_q, state_d;
    logic [IW-1:0]                          idx_q, idx_d;
    logic                                   carry_q, carry_d;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]   a_q, a_d;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]   b_q, b_d;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]   sum_w_q, sum_w_d;
    logic                                   sum_top_q, sum_top_d;

    logic [DATA_WIDTH-1:0] add_s;
    logic                  add_cout;
    logic                  sub_req;

`ifdef MP_ADD_SUB_EN
    assign sub_req = sub;
`else
    assign sub_req = 1'b0;
`endif

    word_adder #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_word_adder (
        .a_i   (a_q[idx_q]),
        .b_i   (b_q[idx_q]),
        .cin_i (carry_q),
        .s_o   (add_s),
        .cout_o(add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_w_q   <= '0;
            sum_top_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_w_q   <= sum_w_d;
            sum_top_q <= sum_top_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_w_d   = sum_w_q;
        sum_top_d = sum_top_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is folded in at capture: B stored inverted, carry seeded with 1.
                    a_d       = a;
                    b_d       = sub_req ? ~b : b;
                    carry_d   = sub_req;
                    idx_d     = '0;
                    sum_w_d   = '0;
                    sum_top_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                sum_w_d[idx_q] = add_s;
                carry_d        = add_cout;
                if (idx_q == LAST) begin
                    sum_top_d = add_cout;
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = {sum_top_q, sum_w_q};

endmodule
